mult_share_arbiter: RTL and testbench

- Shares one signed 24x18 multiply-and-pattern-detect pipeline between NUM_REQ requesters.
- Round-robin arbiter selects one operand pair per cycle and feeds a 2-stage pipeline: operand register, then product/match register.
- Each result goes out on a single response channel tagged with the requester ID, with valid/ready backpressure.
- Sits between the DSP user blocks and the shared multiplier resource; also keeps a saturating global match counter.

---
 rtl/mult_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin shared signed 24x18 multiplier with pattern detect and a saturating match counter.
// Optional runtime pattern/mask compare is enabled with `define MULT_SHARE_CFG_PATTERN_EN.
module mult_share_arbiter #(
    parameter int                 NUM_REQ = 4,
    parameter logic signed [42:0] PATTERN = 43'sd1235678,
    parameter int                 CNT_W   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*24-1:0]        req_a_i,
    input  logic [NUM_REQ*18-1:0]        req_b_i,
`ifdef MULT_SHARE_CFG_PATTERN_EN
    input  logic signed [42:0]           cfg_pattern_i,
    input  logic [42:0]                  cfg_mask_i,
`endif
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id_o,
    output logic signed [42:0]           resp_res_o,
    output logic                         resp_match_o,
    output logic [CNT_W-1:0]             match_cnt_o,
    output logic                         busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantId;
    logic               anyGrant;
    logic               adv1;
    logic               adv2;
    int                 searchIdx;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               s1Valid_q, s1Valid_d;
    logic signed [23:0] s1A_q, s1A_d;
    logic signed [17:0] s1B_q, s1B_d;
    logic [ID_W-1:0]    s1Id_q, s1Id_d;
    logic               s2Valid_q, s2Valid_d;
    logic signed [42:0] s2Res_q, s2Res_d;
    logic               s2Match_q, s2Match_d;
    logic [ID_W-1:0]    s2Id_q, s2Id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic signed [42:0] product;
    logic               productMatch;

    assign adv2 = !s2Valid_q || resp_ready_i;
    assign adv1 = !s1Valid_q || adv2;

    // Search starts at the pointer and wraps, so the first valid requester after the last winner is granted.
    always_comb begin
        grant     = '0;
        grantId   = '0;
        anyGrant  = 1'b0;
        searchIdx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            searchIdx = int'(ptr_q) + i;
            if (searchIdx >= NUM_REQ) begin
                searchIdx = searchIdx - NUM_REQ;
            end
            if (!anyGrant && req_valid_i[searchIdx]) begin
                anyGrant         = 1'b1;
                grant[searchIdx] = 1'b1;
                grantId          = ID_W'(searchIdx);
            end
        end
    end

    assign req_ready_o = (adv1 && rst_ni) ? grant : '0;

    assign product = $signed({{19{s1A_q[23]}}, s1A_q}) * $signed({{25{s1B_q[17]}}, s1B_q});

`ifdef MULT_SHARE_CFG_PATTERN_EN
    assign productMatch = (((product ^ cfg_pattern_i) & ~cfg_mask_i) == 43'd0);
`else
    assign productMatch = (product == PATTERN);
`endif

    always_comb begin
        ptr_d     = ptr_q;
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Id_d    = s1Id_q;
        s2Valid_d = s2Valid_q;
        s2Res_d   = s2Res_q;
        s2Match_d = s2Match_q;
        s2Id_d    = s2Id_q;
        cnt_d     = cnt_q;

        if (adv1) begin
            s1Valid_d = anyGrant;
            if (anyGrant) begin
                s1A_d  = req_a_i[int'(grantId)*24 +: 24];
                s1B_d  = req_b_i[int'(grantId)*18 +: 18];
                s1Id_d = grantId;
                ptr_d  = (grantId == ID_W'(NUM_REQ-1)) ? '0 : grantId + 1'b1;
            end
        end

        if (adv2) begin
            s2Valid_d = s1Valid_q;
            s2Res_d   = product;
            s2Match_d = productMatch;
            s2Id_d    = s1Id_q;
        end

        if (s2Valid_q && resp_ready_i && s2Match_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Id_q    <= '0;
            s2Valid_q <= 1'b0;
            s2Res_q   <= '0;
            s2Match_q <= 1'b0;
            s2Id_q    <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            s1Valid_q <= s1Valid_d;
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Id_q    <= s1Id_d;
            s2Valid_q <= s2Valid_d;
            s2Res_q   <= s2Res_d;
            s2Match_q <= s2Match_d;
            s2Id_q    <= s2Id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign resp_valid_o = s2Valid_q;
    assign resp_id_o    = s2Id_q;
    assign resp_res_o   = s2Res_q;
    assign resp_match_o = s2Match_q;
    assign match_cnt_o  = cnt_q;
    assign busy_o       = s1Valid_q || s2Valid_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter; a second instance with CNT_W=2
// shares all inputs and is used only to observe counter saturation.
module tb_mult_share_arbiter;

    logic               clk;
    logic               rstN;
    logic [3:0]         reqValid;
    logic [3:0]         reqReady;
    logic [95:0]        reqA;
    logic [71:0]        reqB;
    logic               respValid;
    logic               respReady;
    logic [1:0]         respId;
    logic signed [42:0] respRes;
    logic               respMatch;
    logic [15:0]        matchCnt;
    logic               busy;

    logic [3:0]         reqReady2;
    logic               respValid2;
    logic [1:0]         respId2;
    logic signed [42:0] respRes2;
    logic               respMatch2;
    logic [1:0]         matchCnt2;
    logic               busy2;

    int compared   = 0;
    int mismatched = 0;
    int expCnt     = 0;

    mult_share_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_a_i(reqA), .req_b_i(reqB),
        .resp_valid_o(respValid), .resp_ready_i(respReady),
        .resp_id_o(respId), .resp_res_o(respRes), .resp_match_o(respMatch),
        .match_cnt_o(matchCnt), .busy_o(busy)
    );

    mult_share_arbiter #(.NUM_REQ(4), .CNT_W(2)) dutSat (
        .clk_i(clk), .rst_ni(rstN),
        .req_valid_i(reqValid), .req_ready_o(reqReady2),
        .req_a_i(reqA), .req_b_i(reqB),
        .resp_valid_o(respValid2), .resp_ready_i(respReady),
        .resp_id_o(respId2), .resp_res_o(respRes2), .resp_match_o(respMatch2),
        .match_cnt_o(matchCnt2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One isolated transaction into an empty pipeline with the response side always ready.
    task automatic applyStimulus(input int id, input int a, input int b,
                                 input longint expRes, input bit expMatch);
        reqA[24*id +: 24] = 24'(a);
        reqB[18*id +: 18] = 18'(b);
        reqValid          = 4'(1 << id);
        respReady         = 1'b1;
        #1;
        checkOutput("single_ready", reqReady, 64'(1 << id));
        tick();
        reqValid = 4'b0000;
        #1;
        checkOutput("single_lat1_valid", respValid, 0);
        checkOutput("single_lat1_busy", busy, 1);
        tick();
        #1;
        checkOutput("single_valid", respValid, 1);
        checkOutput("single_id", respId, id);
        checkOutput("single_res", respRes, expRes);
        checkOutput("single_match", respMatch, expMatch);
        checkOutput("single_cnt_pre", matchCnt, expCnt);
        tick();
        if (expMatch) expCnt++;
        #1;
        checkOutput("single_drained", respValid, 0);
        checkOutput("single_cnt", matchCnt, expCnt);
        checkOutput("sat_cnt", matchCnt2, (expCnt > 3) ? 3 : expCnt);
        checkOutput("single_idle", busy, 0);
    endtask

    logic [3:0] bpValid  [9] = '{4'b0111, 4'b0110, 4'b0100, 4'b0100, 4'b0100,
                                 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic       bpRdy    [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [3:0] bpExpRdy [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic       bpExpV   [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    int         bpExpId  [9] = '{0, 0, 0, 0, 0, 0, 1, 2, 0};
    int         bpExpRes [9] = '{0, 0, -1000, -1000, -1000, -1000, -2002, -3006, 0};

    initial begin
        rstN      = 1'b0;
        reqValid  = 4'b1111;
        reqA      = '0;
        reqB      = '0;
        respReady = 1'b1;
        #2;
        checkOutput("rst_resp_valid", respValid, 0);
        checkOutput("rst_resp_id", respId, 0);
        checkOutput("rst_resp_res", respRes, 0);
        checkOutput("rst_resp_match", respMatch, 0);
        checkOutput("rst_cnt", matchCnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", reqReady, 0);
        tick();
        rstN     = 1'b1;
        reqValid = 4'b0000;
        tick();

        applyStimulus(2, 617839, 2, 64'sd1235678, 1'b1);
        applyStimulus(0, -617839, -2, 64'sd1235678, 1'b1);
        applyStimulus(1, -617839, 2, -64'sd1235678, 1'b0);
        applyStimulus(3, 8388607, -131072, -64'sd1099511496704, 1'b0);
        applyStimulus(0, 617839, 2, 64'sd1235678, 1'b1);
        applyStimulus(1, 1235678, 1, 64'sd1235678, 1'b1);
        applyStimulus(2, -1235678, -1, 64'sd1235678, 1'b1);

        // Backpressure: three requests while the response side stalls for five cycles.
        for (int k = 0; k < 3; k++) begin
            reqA[24*k +: 24] = 24'(1000 + k);
            reqB[18*k +: 18] = 18'(-(k + 1));
        end
        for (int c = 0; c < 9; c++) begin
            reqValid  = bpValid[c];
            respReady = bpRdy[c];
            #1;
            checkOutput($sformatf("bp_ready_c%0d", c), reqReady, bpExpRdy[c]);
            checkOutput($sformatf("bp_valid_c%0d", c), respValid, bpExpV[c]);
            if (bpExpV[c]) begin
                checkOutput($sformatf("bp_id_c%0d", c), respId, bpExpId[c]);
                checkOutput($sformatf("bp_res_c%0d", c), respRes, bpExpRes[c]);
            end
            tick();
        end
        checkOutput("bp_idle", busy, 0);
        checkOutput("bp_cnt", matchCnt, expCnt);

        // Reset with both stages occupied.
        respReady         = 1'b0;
        reqA[24*1 +: 24]  = 24'd5;
        reqB[18*1 +: 18]  = 18'd5;
        reqA[24*2 +: 24]  = 24'd7;
        reqB[18*2 +: 18]  = 18'd7;
        reqValid          = 4'b0010;
        #1;
        checkOutput("mid_ready_a", reqReady, 4'b0010);
        tick();
        reqValid = 4'b0100;
        #1;
        checkOutput("mid_ready_b", reqReady, 4'b0100);
        tick();
        reqValid = 4'b0000;
        #1;
        checkOutput("mid_full_valid", respValid, 1);
        checkOutput("mid_full_res", respRes, 25);
        checkOutput("mid_full_busy", busy, 1);
        rstN     = 1'b0;
        reqValid = 4'b1111;
        #1;
        expCnt = 0;
        checkOutput("mid_rst_valid", respValid, 0);
        checkOutput("mid_rst_id", respId, 0);
        checkOutput("mid_rst_res", respRes, 0);
        checkOutput("mid_rst_match", respMatch, 0);
        checkOutput("mid_rst_cnt", matchCnt, 0);
        checkOutput("mid_rst_sat_cnt", matchCnt2, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", reqReady, 0);
        tick();
        rstN      = 1'b1;
        reqValid  = 4'b0000;
        respReady = 1'b1;
        tick();
        tick();
        #1;
        checkOutput("post_rst_no_stale", respValid, 0);
        checkOutput("post_rst_busy", busy, 0);
        reqValid = 4'b1100;
        #1;
        checkOutput("post_rst_ptr0", reqReady, 4'b0100);
        reqValid = 4'b0000;
        applyStimulus(3, 617839, 2, 64'sd1235678, 1'b1);

        // Fairness: all four requesters valid for eight cycles.
        for (int k = 0; k < 4; k++) begin
            reqA[24*k +: 24] = 24'(k + 1);
            reqB[18*k +: 18] = 18'd3;
        end
        respReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            reqValid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            checkOutput($sformatf("rr_grant_c%0d", c), reqReady,
                        (c < 8) ? 64'(1 << (c % 4)) : 64'd0);
            if (c >= 2) begin
                checkOutput($sformatf("rr_valid_c%0d", c), respValid, 1);
                checkOutput($sformatf("rr_id_c%0d", c), respId, (c - 2) % 4);
                checkOutput($sformatf("rr_res_c%0d", c), respRes, 3 * ((c - 2) % 4 + 1));
            end
            tick();
        end
        #1;
        checkOutput("rr_drain_valid", respValid, 0);
        checkOutput("rr_drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
